// File: rtl/kyber_pkg.sv
// Kyber constants, INTT state encoding and the standard-domain zeta ROM
// (ZETA[k] = 17^brv7(k) mod q), shared by the ntt/intt datapaths.
package kyber_pkg;

  localparam int KYBER_Q   = 3329;
  localparam int KYBER_N   = 256;
  localparam int INTT_F    = 3303;
  localparam int BARRETT_M = 5039;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_BFLY,
    ST_DRAIN,
    ST_SCALE,
    ST_SDRAIN,
    ST_DONE
  } intt_state_e;

  localparam logic [11:0] ZETA_ROM [0:127] = '{
    12'd1,    12'd1729, 12'd2580, 12'd3289, 12'd2642, 12'd630,  12'd1897, 12'd848,
    12'd1062, 12'd1919, 12'd193,  12'd797,  12'd2786, 12'd3260, 12'd569,  12'd1746,
    12'd296,  12'd2447, 12'd1339, 12'd1476, 12'd3046, 12'd56,   12'd2240, 12'd1333,
    12'd1426, 12'd2094, 12'd535,  12'd2882, 12'd2393, 12'd2879, 12'd1974, 12'd821,
    12'd289,  12'd331,  12'd3253, 12'd1756, 12'd1197, 12'd2304, 12'd2277, 12'd2055,
    12'd650,  12'd1977, 12'd2513, 12'd632,  12'd2865, 12'd33,   12'd1320, 12'd1915,
    12'd2319, 12'd1435, 12'd807,  12'd452,  12'd1438, 12'd2868, 12'd1534, 12'd2402,
    12'd2647, 12'd2617, 12'd1481, 12'd648,  12'd2474, 12'd3110, 12'd1227, 12'd910,
    12'd17,   12'd2761, 12'd583,  12'd2649, 12'd1637, 12'd723,  12'd2288, 12'd1100,
    12'd1409, 12'd2662, 12'd3281, 12'd233,  12'd756,  12'd2156, 12'd3015, 12'd3050,
    12'd1703, 12'd1651, 12'd2789, 12'd1789, 12'd1847, 12'd952,  12'd1461, 12'd2687,
    12'd939,  12'd2308, 12'd2437, 12'd2388, 12'd733,  12'd2337, 12'd268,  12'd641,
    12'd1584, 12'd2298, 12'd2037, 12'd3220, 12'd375,  12'd2549, 12'd2090, 12'd1645,
    12'd1063, 12'd319,  12'd2773, 12'd757,  12'd2099, 12'd561,  12'd2466, 12'd2594,
    12'd2804, 12'd1092, 12'd403,  12'd1026, 12'd1143, 12'd2150, 12'd2775, 12'd886,
    12'd1722, 12'd1212, 12'd1874, 12'd1029, 12'd2110, 12'd2935, 12'd885,  12'd2154
  };

  function automatic logic [11:0] zeta(input logic [6:0] k);
    return ZETA_ROM[k];
  endfunction

endpackage

// File: rtl/intt_gs_butterfly.sv
// Two-stage Gentleman-Sande butterfly mod q with Barrett reduction; in scale mode
// both operands are multiplied by 128^-1 instead. Destination addresses ride along.
module gs_butterfly
  import kyber_pkg::*;
#(
  parameter int WIDTH = 12
) (
  input  logic             clk,
  input  logic             rst_ni,
  input  logic             vld_i,
  input  logic             scale_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [WIDTH-1:0] zeta_i,
  input  logic [7:0]       addr_a_i,
  input  logic [7:0]       addr_b_i,
  output logic             vld_o,
  output logic [WIDTH-1:0] a_o,
  output logic [WIDTH-1:0] b_o,
  output logic [7:0]       addr_a_o,
  output logic [7:0]       addr_b_o
);

  function automatic logic [WIDTH-1:0] cond_sub(input logic [WIDTH:0] x);
    return (x >= (WIDTH+1)'(KYBER_Q)) ? WIDTH'(x - (WIDTH+1)'(KYBER_Q)) : WIDTH'(x);
  endfunction

  // Barrett: t underestimates x/q by at most one, so r < 2q and one subtract suffices.
  function automatic logic [WIDTH-1:0] barrett(input logic [2*WIDTH-1:0] x);
    logic [2*WIDTH+12:0] prod;
    logic [2*WIDTH-1:0]  t;
    logic [2*WIDTH-1:0]  r;
    prod = (2*WIDTH+13)'(x) * (2*WIDTH+13)'(BARRETT_M);
    t    = (2*WIDTH)'(prod >> 24);
    r    = x - t * (2*WIDTH)'(KYBER_Q);
    return cond_sub((WIDTH+1)'(r));
  endfunction

  logic [WIDTH:0]   sum_d, diff_d;
  logic [WIDTH-1:0] x0_d, x1_d, z_d;
  logic [WIDTH-1:0] x0_p1, x1_p1, z_p1;
  logic             scale_p1, vld_p1, vld_p2;
  logic [7:0]       addr_a_p1, addr_b_p1, addr_a_p2, addr_b_p2;
  logic [WIDTH-1:0] a_p2, b_p2;

  always_comb begin
    sum_d  = {1'b0, a_i} + {1'b0, b_i};
    diff_d = {1'b0, b_i} + (WIDTH+1)'(KYBER_Q) - {1'b0, a_i};
    x0_d   = scale_i ? a_i : cond_sub(sum_d);
    x1_d   = scale_i ? b_i : cond_sub(diff_d);
    z_d    = scale_i ? WIDTH'(INTT_F) : zeta_i;
  end

  // stage p1: modular add/sub, operand select
  always_ff @(posedge clk) begin
    if (!rst_ni) vld_p1 <= 1'b0;
    else         vld_p1 <= vld_i;
  end

  always_ff @(posedge clk) begin
    x0_p1     <= x0_d;
    x1_p1     <= x1_d;
    z_p1      <= z_d;
    scale_p1  <= scale_i;
    addr_a_p1 <= addr_a_i;
    addr_b_p1 <= addr_b_i;
  end

  // stage p2: multiply and reduce
  always_ff @(posedge clk) begin
    if (!rst_ni) vld_p2 <= 1'b0;
    else         vld_p2 <= vld_p1;
  end

  always_ff @(posedge clk) begin
    a_p2      <= scale_p1 ? barrett((2*WIDTH)'(x0_p1) * (2*WIDTH)'(INTT_F)) : x0_p1;
    b_p2      <= barrett((2*WIDTH)'(z_p1) * (2*WIDTH)'(x1_p1));
    addr_a_p2 <= addr_a_p1;
    addr_b_p2 <= addr_b_p1;
  end

  assign vld_o    = vld_p2;
  assign a_o      = a_p2;
  assign b_o      = b_p2;
  assign addr_a_o = addr_a_p2;
  assign addr_b_o = addr_b_p2;

endmodule

// File: rtl/intt.sv
// Kyber inverse NTT: 7 GS layers plus a 128^-1 scaling pass over a 256x12 register
// array, one butterfly issue per cycle, with a drain between passes.
module intt
  import kyber_pkg::*;
#(
  parameter int WIDTH    = 12,
  parameter int BFLY_LAT = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             set,
  input  logic             wr_en,
  input  logic [7:0]       wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [7:0]       rd_addr,
  output logic [WIDTH-1:0] rd_data,
  output logic             busy,
  output logic             done
);

  intt_state_e      state_q;
  logic [2:0]       layer_q;
  logic [6:0]       cnt_q, k_q;
  logic             busy_q, done_q;
  logic [WIDTH-1:0] rd_data_q;
  logic [WIDTH-1:0] coef_q [KYBER_N];

  logic [7:0]       len, cnt8, offset, ja_bfly, ja, jb;
  logic             issue, scale, last_in_block;
  logic             bf_vld;
  logic [WIDTH-1:0] bf_a, bf_b;
  logic [7:0]       bf_addr_a, bf_addr_b;

  // Pair index: block number scaled to 2*len, plus offset within the block.
  always_comb begin
    len           = 8'd2 << layer_q;
    cnt8          = {1'b0, cnt_q};
    offset        = cnt8 & (len - 8'd1);
    ja_bfly       = ((cnt8 >> (4'(layer_q) + 4'd1)) << (4'(layer_q) + 4'd2)) | offset;
    scale         = (state_q == ST_SCALE);
    issue         = (state_q == ST_BFLY) || scale;
    ja            = scale ? {cnt_q, 1'b0} : ja_bfly;
    jb            = scale ? {cnt_q, 1'b1} : ja_bfly + len;
    last_in_block = (offset == len - 8'd1);
  end

  gs_butterfly #(.WIDTH(WIDTH)) u_bfly (
    .clk      (clk),
    .rst_ni   (reset),
    .vld_i    (issue),
    .scale_i  (scale),
    .a_i      (coef_q[ja]),
    .b_i      (coef_q[jb]),
    .zeta_i   (WIDTH'(zeta(k_q))),
    .addr_a_i (ja),
    .addr_b_i (jb),
    .vld_o    (bf_vld),
    .a_o      (bf_a),
    .b_o      (bf_b),
    .addr_a_o (bf_addr_a),
    .addr_b_o (bf_addr_b)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      layer_q <= '0;
      cnt_q   <= '0;
      k_q     <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: if (set) begin
          state_q <= ST_BFLY;
          busy_q  <= 1'b1;
          layer_q <= '0;
          cnt_q   <= '0;
          k_q     <= 7'd127;
        end
        ST_BFLY: begin
          cnt_q <= cnt_q + 7'd1;
          if (last_in_block) k_q <= k_q - 7'd1;
          if (cnt_q == 7'd127) state_q <= ST_DRAIN;
        end
        ST_DRAIN: begin
          cnt_q <= cnt_q + 7'd1;
          if (cnt_q == 7'(BFLY_LAT - 1)) begin
            cnt_q <= '0;
            if (layer_q == 3'd6) begin
              state_q <= ST_SCALE;
            end else begin
              layer_q <= layer_q + 3'd1;
              state_q <= ST_BFLY;
            end
          end
        end
        ST_SCALE: begin
          cnt_q <= cnt_q + 7'd1;
          if (cnt_q == 7'd127) state_q <= ST_SDRAIN;
        end
        ST_SDRAIN: begin
          cnt_q <= cnt_q + 7'd1;
          if (cnt_q == 7'(BFLY_LAT - 1)) begin
            cnt_q   <= '0;
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Host writes only while idle; butterfly write-backs only occur while busy.
  always_ff @(posedge clk) begin
    if (wr_en && !busy_q) coef_q[wr_addr] <= wr_data;
    if (bf_vld) begin
      coef_q[bf_addr_a] <= bf_a;
      coef_q[bf_addr_b] <= bf_b;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) rd_data_q <= '0;
    else        rd_data_q <= coef_q[rd_addr];
  end

  assign rd_data = rd_data_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_intt.sv
// Directed bench for intt: zero, constant and scaled-constant inputs, NTT round trip,
// mid-run reset abort, and ignored set/wr_en while busy.
module tb_intt;

  localparam int Q = 3329;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        set = 1'b0;
  logic        wr_en = 1'b0;
  logic [7:0]  wr_addr = '0;
  logic [11:0] wr_data = '0;
  logic [7:0]  rd_addr = '0;
  logic [11:0] rd_data;
  logic        busy, done;

  int n_checks = 0;
  int n_errors = 0;
  int vec   [256];
  int res   [256];
  int exp_v [256];
  int orig  [256];

  always #5 clk = ~clk;

  intt dut (
    .clk     (clk),
    .reset   (reset),
    .set     (set),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .busy    (busy),
    .done    (done)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int brv7(input int k);
    int r = 0;
    for (int i = 0; i < 7; i++) if (k[i]) r |= (1 << (6 - i));
    return r;
  endfunction

  function automatic int zeta_ref(input int k);
    longint r = 1;
    int e = brv7(k);
    for (int i = 0; i < e; i++) r = (r * 17) % Q;
    return int'(r);
  endfunction

  // Forward Kyber NTT (standard domain) on vec[], in place.
  task automatic fwd_ntt();
    int k = 1;
    for (int len = 128; len >= 2; len = len >> 1) begin
      for (int start = 0; start < 256; start += 2 * len) begin
        longint z = longint'(zeta_ref(k));
        k++;
        for (int j = start; j < start + len; j++) begin
          int t = int'((z * longint'(vec[j + len])) % Q);
          vec[j + len] = (vec[j] + Q - t) % Q;
          vec[j]       = (vec[j] + t) % Q;
        end
      end
    end
  endtask

  task automatic load();
    for (int i = 0; i < 256; i++) begin
      wr_en   = 1'b1;
      wr_addr = 8'(i);
      wr_data = 12'(vec[i]);
      tick();
    end
    wr_en = 1'b0;
  endtask

  task automatic read_all();
    for (int i = 0; i < 256; i++) begin
      rd_addr = 8'(i);
      tick();
      res[i] = int'(rd_data);
    end
  endtask

  task automatic check_res(input string tag);
    for (int i = 0; i < 256; i++) chk($sformatf("%s[%0d]", tag, i), res[i], exp_v[i]);
  endtask

  // Start a run (optionally with a coincident write), optionally pulse set+wr_en at cycle inj.
  task automatic run(input string tag, input bit pre_wr, input int pa, input int pd, input int inj);
    int cyc;
    set = 1'b1;
    if (pre_wr) begin
      wr_en = 1'b1; wr_addr = 8'(pa); wr_data = 12'(pd);
    end
    tick();
    set = 1'b0; wr_en = 1'b0;
    chk({tag, "_busy_start"}, busy, 1);
    for (cyc = 1; cyc <= 1200; cyc++) begin
      if (cyc == inj) begin
        set = 1'b1; wr_en = 1'b1; wr_addr = 8'd0; wr_data = 12'd123;
      end
      tick();
      set = 1'b0; wr_en = 1'b0;
      if (done) break;
    end
    chk({tag, "_done_cycle"}, cyc, 1040);
    chk({tag, "_busy_at_done"}, busy, 0);
    tick();
    chk({tag, "_done_pulse_len"}, done, 0);
  endtask

  task automatic const_pattern(input int v);
    for (int i = 0; i < 256; i++) begin
      vec[i]   = (i % 2 == 0) ? v : 0;
      exp_v[i] = (i == 0) ? v : 0;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int ndone;
    #1;
    tick(); tick();
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_rd_data", rd_data, 0);
    reset = 1'b1;
    tick();

    // all-zero input
    for (int i = 0; i < 256; i++) begin vec[i] = 0; exp_v[i] = 0; end
    load();
    run("zero", 1'b0, 0, 0, 0);
    read_all();
    check_res("zero");

    // NTT of constant 1; last nonzero entry written together with set
    const_pattern(1);
    vec[254] = 0;
    load();
    run("one", 1'b1, 254, 1, 0);
    read_all();
    check_res("one");

    // linearity: constant 5
    const_pattern(5);
    load();
    run("five", 1'b0, 0, 0, 0);
    read_all();
    check_res("five");

    // round trip: random poly -> forward NTT -> intt
    for (int i = 0; i < 256; i++) begin
      orig[i]  = int'($urandom_range(0, Q - 1));
      vec[i]   = orig[i];
      exp_v[i] = orig[i];
    end
    fwd_ntt();
    load();
    run("rtrip", 1'b0, 0, 0, 0);
    read_all();
    check_res("rtrip");

    // reset mid-run at cycle 500 aborts without a done pulse
    const_pattern(1);
    load();
    set = 1'b1;
    tick();
    set = 1'b0;
    repeat (499) tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    ndone = 0;
    repeat (1100) begin
      tick();
      if (done) ndone++;
    end
    chk("abort_no_done", ndone, 0);
    const_pattern(5);
    load();
    run("after_abort", 1'b0, 0, 0, 0);
    read_all();
    check_res("after_abort");

    // set and wr_en mid-run are ignored
    for (int i = 0; i < 256; i++) begin vec[i] = orig[i]; exp_v[i] = orig[i]; end
    fwd_ntt();
    load();
    run("midrun", 1'b0, 0, 0, 300);
    read_all();
    check_res("midrun");

    // set coincident with reset is ignored
    reset = 1'b0; set = 1'b1;
    tick();
    reset = 1'b1; set = 1'b0;
    tick();
    chk("set_with_reset_busy", busy, 0);
    chk("set_with_reset_done", done, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
